// File: rtl/ct_pkt_fifo_if.sv
// rtl/ct_pkt_fifo_if.sv - valid/ready/eop stream bundle for ct_pkt_fifo
interface ct_pkt_fifo_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_eop;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_eop;
  logic             o_valid;
  logic             i_ready;
  logic [AW:0]      o_level;
  logic [AW:0]      o_pkts;

  modport slave (
    input  i_data, i_valid, i_eop, i_ready,
    output o_ready, o_data, o_eop, o_valid, o_level, o_pkts
  );

  modport master (
    output i_data, i_valid, i_eop, i_ready,
    input  o_ready, o_data, o_eop, o_valid, o_level, o_pkts
  );
endinterface

// File: rtl/ct_pkt_fifo.sv
// rtl/ct_pkt_fifo.sv - packet-aware FIFO, cut-through or store-and-forward
module ct_pkt_fifo #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 16,
  parameter int STORE_FWD = 0
) (
  input  logic         clk,
  input  logic         reset,
  ct_pkt_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {ST_HOLD, ST_FORCE} state_t;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_level;
  logic [AW:0]      r_pkts;
  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_valid;
  logic             w_wr;
  logic             w_rd;
  logic             w_pkt_in;
  logic             w_pkt_out;
  logic             w_head_eop;
  logic [WIDTH-1:0] w_head_data;

  assign w_full   = (r_level == FULL_LVL);
  assign w_empty  = (r_level == '0);
  // A same-cycle read never frees a slot for the write: full means not ready.
  assign w_ready  = !reset && !w_full;
  assign w_wr     = bus.i_valid && w_ready;
  assign w_rd     = w_valid && bus.i_ready;
  assign {w_head_eop, w_head_data} = r_mem[r_rd_ptr];
  assign w_pkt_in  = w_wr && bus.i_eop;
  assign w_pkt_out = w_rd && w_head_eop;

  // HOLD presents only complete packets; FORCE streams an oversize packet out.
  always_comb begin
    w_valid = !w_empty;
    if (STORE_FWD != 0 && r_state == ST_HOLD) begin
      w_valid = (r_pkts != '0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (STORE_FWD != 0) begin
      case (r_state)
        ST_HOLD:  if (w_full && r_pkts == '0) w_state_nxt = ST_FORCE;
        ST_FORCE: if (w_pkt_out) w_state_nxt = ST_HOLD;
        default:  w_state_nxt = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {bus.i_eop, bus.i_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_pkts   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkts <= r_pkts + 1'b1;
        2'b01:   r_pkts <= r_pkts - 1'b1;
        default: r_pkts <= r_pkts;
      endcase
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = w_valid;
  assign bus.o_data  = w_head_data;
  assign bus.o_eop   = w_head_eop;
  assign bus.o_level = r_level;
  assign bus.o_pkts  = r_pkts;
endmodule

// File: tb/tb_ct_pkt_fifo.sv
// tb/tb_ct_pkt_fifo.sv - cut-through and store-and-forward instances against a queue model
module tb_ct_pkt_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] d_data;
  logic d_valid, d_eop, d_ready;

  always #5 clk = ~clk;

  ct_pkt_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ct_if ();
  ct_pkt_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) sf_if ();

  assign ct_if.i_data  = d_data;
  assign ct_if.i_valid = d_valid;
  assign ct_if.i_eop   = d_eop;
  assign ct_if.i_ready = d_ready;
  assign sf_if.i_data  = d_data;
  assign sf_if.i_valid = d_valid;
  assign sf_if.i_eop   = d_eop;
  assign sf_if.i_ready = d_ready;

  ct_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
    .clk   (clk),
    .reset (reset),
    .bus   (ct_if)
  );

  ct_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
    .clk   (clk),
    .reset (reset),
    .bus   (sf_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_deliv_sf = 0;

  // Reference contents as ordered word lists {eop, data}; m_force marks an oversize packet streaming out.
  logic [WIDTH:0] mq0[$];
  logic [WIDTH:0] mq1[$];
  bit m_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int m_level(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int m_pkts(input int k);
    int n = 0;
    if (k == 0) begin
      foreach (mq0[i]) n += int'(mq0[i][WIDTH]);
    end else begin
      foreach (mq1[i]) n += int'(mq1[i][WIDTH]);
    end
    return n;
  endfunction

  function automatic logic [WIDTH:0] m_head(input int k);
    if (m_level(k) == 0) return '0;
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic bit exp_ready(input int k);
    return !reset && (m_level(k) != DEPTH);
  endfunction

  function automatic bit exp_valid(input int k);
    if (k == 0 || m_force) return m_level(k) != 0;
    return m_pkts(k) != 0;
  endfunction

  task automatic check_dut(input int k);
    logic rdy, vld, eop;
    logic [WIDTH-1:0] dat;
    logic [2:0] lvl, pk;
    logic [WIDTH:0] hd;
    string n;
    n = (k == 0) ? "ct" : "sf";
    if (k == 0) begin
      rdy = ct_if.o_ready; vld = ct_if.o_valid; eop = ct_if.o_eop;
      dat = ct_if.o_data; lvl = ct_if.o_level; pk = ct_if.o_pkts;
    end else begin
      rdy = sf_if.o_ready; vld = sf_if.o_valid; eop = sf_if.o_eop;
      dat = sf_if.o_data; lvl = sf_if.o_level; pk = sf_if.o_pkts;
    end
    chk({n, ".ready"}, 32'(rdy), 32'(exp_ready(k)));
    chk({n, ".valid"}, 32'(vld), 32'(exp_valid(k)));
    chk({n, ".level"}, 32'(lvl), 32'(m_level(k)));
    chk({n, ".pkts"},  32'(pk),  32'(m_pkts(k)));
    if (exp_valid(k)) begin
      hd = m_head(k);
      chk({n, ".data"}, 32'(dat), 32'(hd[WIDTH-1:0]));
      chk({n, ".eop"},  32'(eop), 32'(hd[WIDTH]));
    end
  endtask

  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit e, input bit r, input bit rst);
    bit wr0, wr1, rd0, rd1, nf;
    logic [WIDTH:0] hd;
    @(negedge clk);
    d_valid = v; d_data = d; d_eop = e; d_ready = r; reset = rst;
    if (rst) begin
      mq0.delete(); mq1.delete(); m_force = 1'b0;
    end
    #1;
    check_dut(0);
    check_dut(1);
    wr0 = v && exp_ready(0);
    wr1 = v && exp_ready(1);
    rd0 = exp_valid(0) && r;
    rd1 = exp_valid(1) && r;
    hd = m_head(1);
    if (!m_force) nf = (m_level(1) == DEPTH) && (m_pkts(1) == 0);
    else          nf = !(rd1 && hd[WIDTH]);
    if (rd0) void'(mq0.pop_front());
    if (rd1) begin
      void'(mq1.pop_front());
      n_deliv_sf++;
    end
    if (wr0) mq0.push_back({e, d});
    if (wr1) mq1.push_back({e, d});
    m_force = nf;
    @(posedge clk);
  endtask

  task automatic reset_pulse();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((m_level(0) != 0 || m_level(1) != 0) && t < budget) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      t++;
    end
    chk("drain.ct_level", 32'(m_level(0)), 32'd0);
    chk("drain.sf_level", 32'(m_level(1)), 32'd0);
  endtask

  initial begin
    int tries;
    reset = 1'b1; d_valid = 1'b0; d_data = '0; d_eop = 1'b0; d_ready = 1'b0;

    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // single non-EOP word: visible next cycle only in cut-through
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t1.ct_valid", 32'(ct_if.o_valid), 32'd1);
    chk("t1.ct_data",  32'(ct_if.o_data),  32'hA1);
    chk("t1.ct_level", 32'(ct_if.o_level), 32'd1);
    chk("t1.sf_valid", 32'(sf_if.o_valid), 32'd0);

    // fill, then one read with i_valid held
    reset_pulse();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    #2;
    chk("fill.ct_ready", 32'(ct_if.o_ready), 32'd0);
    chk("fill.ct_level", 32'(ct_if.o_level), 32'd4);
    cycle(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    #2;
    chk("fill.ct_ready_after_read", 32'(ct_if.o_ready), 32'd1);
    cycle(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    #2;
    chk("fill.ct_ready_refull", 32'(ct_if.o_ready), 32'd0);

    // store-and-forward holds a 3-word packet until its EOP is stored
    reset_pulse();
    cycle(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    #2;
    chk("sf3.sf_valid", 32'(sf_if.o_valid), 32'd1);
    chk("sf3.sf_pkts",  32'(sf_if.o_pkts),  32'd1);
    drain(20);

    // simultaneous EOP read and EOP write at level 2 / pkts 1
    reset_pulse();
    cycle(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b1, 1'b1, 1'b0);
    #2;
    chk("rw.ct_level", 32'(ct_if.o_level), 32'd2);
    chk("rw.ct_pkts",  32'(ct_if.o_pkts),  32'd1);
    chk("rw.sf_level", 32'(sf_if.o_level), 32'd2);
    chk("rw.sf_pkts",  32'(sf_if.o_pkts),  32'd1);

    // oversize packet forces store-and-forward into cut-through
    reset_pulse();
    n_deliv_sf = 0;
    for (int i = 0; i < 6; i++) begin
      tries = 0;
      while (!exp_ready(1) && tries < 20) begin
        cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        tries++;
      end
      chk("big.accept_wait", 32'(tries < 20), 32'd1);
      cycle(1'b1, 8'(8'h50 + i), i == 5, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain(30);
    chk("big.sf_words", 32'(n_deliv_sf), 32'd6);
    cycle(1'b1, 8'h60, 1'b0, 1'b1, 1'b0);
    #2;
    chk("big.sf_hold_after", 32'(sf_if.o_valid), 32'd0);

    // random traffic through wraparound
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) > 1, 1'b0);
    end

    // reset mid-packet, then a clean packet
    reset_pulse();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst.ct_level", 32'(ct_if.o_level), 32'd0);
    chk("rst.sf_pkts",  32'(sf_if.o_pkts),  32'd0);
    chk("rst.sf_valid", 32'(sf_if.o_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), i == 2, 1'b0, 1'b0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
